rvh_ptw_mem_responder: RTL and testbench

RVH_PTW_MEM_RESPONDER -- requirements
Module: rvh_ptw_mem_responder

---
 rtl/rvh_ptw_mem_responder_pkg.sv | 27 ++
 rtl/rvh_ptw_req_queue.sv | 76 +++++++
 rtl/rvh_ptw_mem_responder.sv | 135 +++++++++++++
 tb/tb_rvh_ptw_mem_responder.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvh_ptw_mem_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rvh_ptw_mem_responder_pkg                                            |
// | Shared MMU definitions: PTE geometry and page-walk queue entry.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package rvh_ptw_mem_responder_pkg;

    localparam int unsigned C_PTE_WIDTH        = 64;
    localparam logic [C_PTE_WIDTH-1:0] C_PTE_ZERO = '0;

    // Entry field widths track the default walker configuration.
    localparam int unsigned C_MMU_PADDR_WIDTH  = 56;
    localparam int unsigned C_MMU_PTW_ID_WIDTH = 1;

    typedef struct packed {
        logic [C_MMU_PTW_ID_WIDTH-1:0] id;
        logic [C_MMU_PADDR_WIDTH-1:0]  addr;
        logic                          nomem;
    } ptw_req_entry_t;

    function automatic logic pte_addr_misaligned(input logic [2:0] i_lsb);
        return i_lsb != 3'b000;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rvh_ptw_req_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rvh_ptw_req_queue                                                    |
// | In-order walk request queue with head (retire) and issue pointers.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rvh_ptw_req_queue
    import rvh_ptw_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          i_push,
    input  ptw_req_entry_t                i_push_entry,
    output logic                          o_full,
    input  logic                          i_pop,
    output logic                          o_head_vld,
    output logic                          o_head_nomem,
    output logic                          o_iss_vld,
    output logic [C_MMU_PADDR_WIDTH-1:0]  o_iss_addr,
    input  logic                          i_iss_hs
);

    localparam int unsigned   C_AW      = $clog2(DEPTH);
    localparam logic [C_AW:0] C_PTR_ONE = (C_AW+1)'(1);

    ptw_req_entry_t r_mem [DEPTH];
    logic [C_AW:0]  r_wr_ptr;
    logic [C_AW:0]  r_rd_ptr;
    logic [C_AW:0]  r_iss_ptr;

    ptw_req_entry_t w_head_entry;
    ptw_req_entry_t w_iss_entry;
    logic           w_iss_pending;
    logic           w_iss_adv;

    always_comb begin
        w_head_entry  = r_mem[r_rd_ptr[C_AW-1:0]];
        w_iss_entry   = r_mem[r_iss_ptr[C_AW-1:0]];
        w_iss_pending = (r_iss_ptr != r_wr_ptr);
        // Entries that need no memory access are stepped over one per cycle.
        w_iss_adv     = w_iss_pending && (w_iss_entry.nomem || i_iss_hs);

        o_full        = (r_wr_ptr[C_AW] != r_rd_ptr[C_AW]) &&
                        (r_wr_ptr[C_AW-1:0] == r_rd_ptr[C_AW-1:0]);
        o_head_vld    = (r_wr_ptr != r_rd_ptr);
        o_head_nomem  = w_head_entry.nomem;
        o_iss_vld     = w_iss_pending && !w_iss_entry.nomem;
        o_iss_addr    = w_iss_entry.addr;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_iss_ptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr[C_AW-1:0]] <= i_push_entry;
                r_wr_ptr                  <= r_wr_ptr + C_PTR_ONE;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            if (w_iss_adv) begin
                r_iss_ptr <= r_iss_ptr + C_PTR_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rvh_ptw_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rvh_ptw_mem_responder                                                |
// | Turns page-walk PTE reads into in-order memory reads and responses.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rvh_ptw_mem_responder
    import rvh_ptw_mem_responder_pkg::*;
#(
    parameter int unsigned PADDR_WIDTH  = 56,
    parameter int unsigned PTW_ID_WIDTH = 1,
    parameter int unsigned DEPTH        = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    ptw_walk_req_vld_i,
    input  logic [PTW_ID_WIDTH-1:0] ptw_walk_req_id_i,
    input  logic [PADDR_WIDTH-1:0]  ptw_walk_req_addr_i,
    output logic                    ptw_walk_req_rdy_o,
    output logic                    ptw_walk_resp_vld_o,
    output logic [C_PTE_WIDTH-1:0]  ptw_walk_resp_pte_o,
    input  logic                    ptw_walk_resp_rdy_i,
    output logic                    mem_req_vld_o,
    output logic [PADDR_WIDTH-1:0]  mem_req_addr_o,
    input  logic                    mem_req_rdy_i,
    input  logic                    mem_resp_vld_i,
    input  logic [C_PTE_WIDTH-1:0]  mem_resp_data_i,
    input  logic                    mem_resp_err_i,
    output logic                    mem_resp_rdy_o,
    output logic                    protocol_err_o
);

    localparam int unsigned          C_CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [C_CNT_W-1:0]   C_CNT_ONE = C_CNT_W'(1);

    logic                          r_rdy_en;
    logic [C_CNT_W-1:0]            r_outstanding;
    logic                          r_resp_vld;
    logic [C_PTE_WIDTH-1:0]        r_resp_pte;
    logic                          r_protocol_err;

    ptw_req_entry_t                w_push_entry;
    logic                          w_push;
    logic                          w_full;
    logic                          w_head_vld;
    logic                          w_head_nomem;
    logic                          w_iss_vld;
    logic [C_MMU_PADDR_WIDTH-1:0]  w_iss_addr;
    logic                          w_mem_req_hs;
    logic                          w_mem_resp_hs;
    logic                          w_drain;
    logic                          w_resp_free;
    logic                          w_nomem_load;
    logic                          w_load;
    logic                          w_spurious;
    logic [C_PTE_WIDTH-1:0]        w_load_pte;

    rvh_ptw_req_queue #(
        .DEPTH (DEPTH)
    ) u_req_queue (
        .clk          (clk),
        .rstn         (rstn),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .o_full       (w_full),
        .i_pop        (w_load),
        .o_head_vld   (w_head_vld),
        .o_head_nomem (w_head_nomem),
        .o_iss_vld    (w_iss_vld),
        .o_iss_addr   (w_iss_addr),
        .i_iss_hs     (w_mem_req_hs)
    );

    always_comb begin
        // r_rdy_en keeps the request port closed until the first edge after reset.
        ptw_walk_req_rdy_o = r_rdy_en && !w_full;
        w_push             = ptw_walk_req_vld_i && ptw_walk_req_rdy_o;

        w_push_entry.id    = C_MMU_PTW_ID_WIDTH'(ptw_walk_req_id_i);
        w_push_entry.addr  = C_MMU_PADDR_WIDTH'(ptw_walk_req_addr_i);
        w_push_entry.nomem = pte_addr_misaligned(ptw_walk_req_addr_i[2:0]);

        mem_req_vld_o      = w_iss_vld;
        mem_req_addr_o     = PADDR_WIDTH'(w_iss_addr);
        w_mem_req_hs       = mem_req_vld_o && mem_req_rdy_i;

        w_drain            = r_resp_vld && ptw_walk_resp_rdy_i;
        w_resp_free        = !r_resp_vld || w_drain;

        // A nonzero count implies the head is the oldest issued read.
        mem_resp_rdy_o     = w_head_vld && !w_head_nomem && w_resp_free &&
                             (r_outstanding != '0);
        w_mem_resp_hs      = mem_resp_vld_i && mem_resp_rdy_o;
        w_spurious         = mem_resp_vld_i && (r_outstanding == '0);

        w_nomem_load       = w_head_vld && w_head_nomem && w_resp_free;
        w_load             = w_nomem_load || w_mem_resp_hs;
        w_load_pte         = (w_nomem_load || mem_resp_err_i) ? C_PTE_ZERO : mem_resp_data_i;

        ptw_walk_resp_vld_o = r_resp_vld;
        ptw_walk_resp_pte_o = r_resp_pte;
        protocol_err_o      = r_protocol_err;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rdy_en       <= 1'b0;
            r_outstanding  <= '0;
            r_resp_vld     <= 1'b0;
            r_resp_pte     <= C_PTE_ZERO;
            r_protocol_err <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;

            case ({w_mem_req_hs, w_mem_resp_hs})
                2'b10:   r_outstanding <= r_outstanding + C_CNT_ONE;
                2'b01:   r_outstanding <= r_outstanding - C_CNT_ONE;
                default: r_outstanding <= r_outstanding;
            endcase

            if (w_load) begin
                r_resp_vld <= 1'b1;
                r_resp_pte <= w_load_pte;
            end else if (w_drain) begin
                r_resp_vld <= 1'b0;
            end

            if (w_spurious) begin
                r_protocol_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rvh_ptw_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rvh_ptw_mem_responder                                             |
// | Directed and random stimulus against an in-order PTE fetch model.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_rvh_ptw_mem_responder;

    localparam int unsigned PADDR_WIDTH  = 56;
    localparam int unsigned PTW_ID_WIDTH = 1;
    localparam int unsigned DEPTH        = 4;

    logic                    clk = 1'b0;
    logic                    rstn;
    logic                    ptw_walk_req_vld_i;
    logic [PTW_ID_WIDTH-1:0] ptw_walk_req_id_i;
    logic [PADDR_WIDTH-1:0]  ptw_walk_req_addr_i;
    logic                    ptw_walk_req_rdy_o;
    logic                    ptw_walk_resp_vld_o;
    logic [63:0]             ptw_walk_resp_pte_o;
    logic                    ptw_walk_resp_rdy_i;
    logic                    mem_req_vld_o;
    logic [PADDR_WIDTH-1:0]  mem_req_addr_o;
    logic                    mem_req_rdy_i;
    logic                    mem_resp_vld_i;
    logic [63:0]             mem_resp_data_i;
    logic                    mem_resp_err_i;
    logic                    mem_resp_rdy_o;
    logic                    protocol_err_o;

    always #5 clk = ~clk;

    rvh_ptw_mem_responder #(
        .PADDR_WIDTH  (PADDR_WIDTH),
        .PTW_ID_WIDTH (PTW_ID_WIDTH),
        .DEPTH        (DEPTH)
    ) dut (
        .clk                 (clk),
        .rstn                (rstn),
        .ptw_walk_req_vld_i  (ptw_walk_req_vld_i),
        .ptw_walk_req_id_i   (ptw_walk_req_id_i),
        .ptw_walk_req_addr_i (ptw_walk_req_addr_i),
        .ptw_walk_req_rdy_o  (ptw_walk_req_rdy_o),
        .ptw_walk_resp_vld_o (ptw_walk_resp_vld_o),
        .ptw_walk_resp_pte_o (ptw_walk_resp_pte_o),
        .ptw_walk_resp_rdy_i (ptw_walk_resp_rdy_i),
        .mem_req_vld_o       (mem_req_vld_o),
        .mem_req_addr_o      (mem_req_addr_o),
        .mem_req_rdy_i       (mem_req_rdy_i),
        .mem_resp_vld_i      (mem_resp_vld_i),
        .mem_resp_data_i     (mem_resp_data_i),
        .mem_resp_err_i      (mem_resp_err_i),
        .mem_resp_rdy_o      (mem_resp_rdy_o),
        .protocol_err_o      (protocol_err_o)
    );

    typedef struct {
        logic [63:0] data;
        logic        err;
        int          ready;
    } mem_rd_t;

    logic [63:0]            exp_q[$];   // PTEs the walker must see, in request order
    logic [PADDR_WIDTH-1:0] iss_q[$];   // aligned addresses the memory must see, in order
    mem_rd_t                mem_q[$];   // reads accepted by the memory model
    int                     lat_q[$];

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    logic        ovr_en   = 1'b0;
    logic [63:0] ovr_data = '0;
    logic        ovr_err  = 1'b0;
    logic        err_en   = 1'b0;
    int          lat_max  = 0;
    logic        spur     = 1'b0;
    logic        hold_resp = 1'b0;
    logic [63:0] hold_pte  = '0;
    logic        hold_mreq = 1'b0;
    logic [PADDR_WIDTH-1:0] hold_addr = '0;

    function automatic logic [63:0] mem_data(input logic [PADDR_WIDTH-1:0] a);
        if (ovr_en) return ovr_data;
        return {a[31:0] ^ 32'hC3A5_0F1E, a[55:24]};
    endfunction

    function automatic logic mem_err(input logic [PADDR_WIDTH-1:0] a);
        if (ovr_en) return ovr_err;
        return err_en && (a[6:3] == 4'hF);
    endfunction

    // Misaligned PTE addresses and faulted reads both yield an invalid (zero) PTE.
    function automatic logic [63:0] exp_pte(input logic [PADDR_WIDTH-1:0] a);
        if (a[2:0] != 3'b000) return 64'h0;
        if (mem_err(a))       return 64'h0;
        return mem_data(a);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        int                     lat;
        logic [PADDR_WIDTH-1:0] a;
        mem_resp_vld_i  = 1'b0;
        mem_resp_err_i  = 1'b0;
        mem_resp_data_i = {$urandom, $urandom};
        if (spur) begin
            mem_resp_vld_i = 1'b1;
        end else if (mem_q.size() > 0 && mem_q[0].ready <= cyc) begin
            mem_resp_vld_i  = 1'b1;
            mem_resp_data_i = mem_q[0].data;
            mem_resp_err_i  = mem_q[0].err;
        end
        #1;
        if (hold_resp) begin
            chk("resp_hold_vld", ptw_walk_resp_vld_o, 1);
            chk("resp_hold_pte", ptw_walk_resp_pte_o, hold_pte);
        end
        if (hold_mreq) begin
            chk("mreq_hold_vld", mem_req_vld_o, 1);
            chk("mreq_hold_addr", mem_req_addr_o, hold_addr);
        end
        if (ptw_walk_resp_vld_o && ptw_walk_resp_rdy_i) begin
            if (exp_q.size() == 0) begin
                chk("resp_unexpected", ptw_walk_resp_vld_o, 0);
            end else begin
                chk("resp_pte", ptw_walk_resp_pte_o, exp_q[0]);
                void'(exp_q.pop_front());
            end
        end
        if (mem_req_vld_o) begin
            if (iss_q.size() == 0) begin
                chk("mreq_unexpected", mem_req_vld_o, 0);
            end else begin
                chk("mreq_addr", mem_req_addr_o, iss_q[0]);
                if (mem_req_rdy_i) begin
                    a   = iss_q.pop_front();
                    lat = (lat_q.size() > 0) ? lat_q.pop_front() : int'($urandom_range(lat_max, 0));
                    mem_q.push_back('{data: mem_data(a), err: mem_err(a), ready: cyc + 1 + lat});
                end
            end
        end
        if (spur) begin
            chk("spur_rdy", mem_resp_rdy_o, 0);
        end else if (mem_resp_vld_i && mem_resp_rdy_o) begin
            void'(mem_q.pop_front());
        end
        if (ptw_walk_req_vld_i && ptw_walk_req_rdy_o) begin
            exp_q.push_back(exp_pte(ptw_walk_req_addr_i));
            if (ptw_walk_req_addr_i[2:0] == 3'b000) iss_q.push_back(ptw_walk_req_addr_i);
        end
        hold_resp = ptw_walk_resp_vld_o && !ptw_walk_resp_rdy_i;
        hold_pte  = ptw_walk_resp_pte_o;
        hold_mreq = mem_req_vld_o && !mem_req_rdy_i;
        hold_addr = mem_req_addr_o;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic send(input logic [PADDR_WIDTH-1:0] a);
        ptw_walk_req_vld_i  = 1'b1;
        ptw_walk_req_id_i   = PTW_ID_WIDTH'($urandom);
        ptw_walk_req_addr_i = a;
        tick();
        ptw_walk_req_vld_i  = 1'b0;
    endtask

    task automatic wait_resp(input string tag, input logic [63:0] pte, input int budget);
        int n = 0;
        while (!ptw_walk_resp_vld_o && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_vld"}, ptw_walk_resp_vld_o, 1);
        chk({tag, "_pte"}, ptw_walk_resp_pte_o, pte);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_rdy"},  ptw_walk_req_rdy_o, 0);
        chk({tag, "_resp_vld"}, ptw_walk_resp_vld_o, 0);
        chk({tag, "_resp_pte"}, ptw_walk_resp_pte_o, 0);
        chk({tag, "_mreq_vld"}, mem_req_vld_o, 0);
        chk({tag, "_mresp_rdy"}, mem_resp_rdy_o, 0);
        chk({tag, "_perr"},     protocol_err_o, 0);
    endtask

    task automatic flush_model();
        exp_q.delete();
        iss_q.delete();
        mem_q.delete();
        lat_q.delete();
        hold_resp = 1'b0;
        hold_mreq = 1'b0;
    endtask

    initial begin
        logic [PADDR_WIDTH-1:0] ba [4];
        int                     n;

        rstn                = 1'b0;
        ptw_walk_req_vld_i  = 1'b0;
        ptw_walk_req_id_i   = '0;
        ptw_walk_req_addr_i = '0;
        ptw_walk_resp_rdy_i = 1'b1;
        mem_req_rdy_i       = 1'b1;
        mem_resp_vld_i      = 1'b0;
        mem_resp_data_i     = '0;
        mem_resp_err_i      = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("por");
        rstn = 1'b1;
        tick();
        chk("rdy_after_rst", ptw_walk_req_rdy_o, 1);

        // Single aligned request, zero-wait memory: 3-cycle latency.
        ovr_en = 1'b1; ovr_data = 64'h0000_0000_2000_0001; ovr_err = 1'b0;
        chk("t0_rdy", ptw_walk_req_rdy_o, 1);
        send(56'h8000_1008);
        chk("t1_mreq_vld", mem_req_vld_o, 1);
        chk("t1_mreq_addr", mem_req_addr_o, 56'h8000_1008);
        tick();
        chk("t2_resp_vld", ptw_walk_resp_vld_o, 0);
        tick();
        chk("t3_resp_vld", ptw_walk_resp_vld_o, 1);
        chk("t3_resp_pte", ptw_walk_resp_pte_o, 64'h2000_0001);
        tick();
        chk("t4_resp_vld", ptw_walk_resp_vld_o, 0);

        // Misaligned request: no memory read, zero PTE.
        send(56'h8000_1004);
        chk("mis_t1_mreq", mem_req_vld_o, 0);
        tick();
        chk("mis_t2_mreq", mem_req_vld_o, 0);
        chk("mis_t2_vld", ptw_walk_resp_vld_o, 1);
        chk("mis_t2_pte", ptw_walk_resp_pte_o, 0);
        tick();

        // Bus error with nonzero data.
        ovr_data = 64'hFFFF; ovr_err = 1'b1;
        send(56'h8000_2010);
        wait_resp("err", 64'h0, 10);
        tick();
        ovr_err = 1'b0; ovr_en = 1'b0;

        // Fill the queue with the walker and memory stalled, then release.
        ptw_walk_resp_rdy_i = 1'b0;
        mem_req_rdy_i       = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ba[i] = 56'h9000_0000 + PADDR_WIDTH'(i * 8);
            chk("fill_rdy", ptw_walk_req_rdy_o, 1);
            send(ba[i]);
        end
        chk("full_rdy", ptw_walk_req_rdy_o, 0);
        tick();
        chk("full_rdy_hold", ptw_walk_req_rdy_o, 0);
        ptw_walk_resp_rdy_i = 1'b1;
        mem_req_rdy_i       = 1'b1;
        wait_resp("burst0", exp_pte(ba[0]), 10);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("burst_vld", ptw_walk_resp_vld_o, 1);
            chk("burst_pte", ptw_walk_resp_pte_o, exp_pte(ba[i]));
        end
        tick();

        // Aligned / misaligned / aligned with the first read delayed.
        lat_q.push_back(5);
        send(56'hA000_0000);
        send(56'hA000_0102);
        send(56'hA000_0208);
        wait_resp("ord0", exp_pte(56'hA000_0000), 20);
        tick();
        wait_resp("ord1", 64'h0, 5);
        tick();
        wait_resp("ord2", exp_pte(56'hA000_0208), 10);
        tick();

        // Spurious memory response while idle.
        spur = 1'b1;
        tick();
        spur = 1'b0;
        chk("perr_set", protocol_err_o, 1);
        chk("spur_no_resp", ptw_walk_resp_vld_o, 0);
        tick();
        chk("perr_sticky", protocol_err_o, 1);
        chk("spur_no_resp2", ptw_walk_resp_vld_o, 0);

        // Reset with two reads outstanding.
        lat_q.push_back(30);
        lat_q.push_back(30);
        send(56'hB000_0000);
        send(56'hB000_0008);
        repeat (3) tick();
        chk("pre_rst_mresp_rdy", mem_resp_rdy_o, 1);
        rstn = 1'b0;
        #1;
        chk_reset_outputs("mid");
        repeat (2) @(negedge clk);
        flush_model();
        rstn = 1'b1;
        tick();
        chk("post_rst_rdy", ptw_walk_req_rdy_o, 1);
        chk("post_rst_mreq", mem_req_vld_o, 0);
        send(56'hC000_0010);
        wait_resp("post_rst", exp_pte(56'hC000_0010), 10);
        tick();

        // Random traffic against the in-order model.
        err_en  = 1'b1;
        lat_max = 3;
        for (int c = 0; c < 600; c++) begin
            ptw_walk_req_vld_i  = 1'($urandom);
            ptw_walk_req_id_i   = PTW_ID_WIDTH'($urandom);
            ptw_walk_req_addr_i = PADDR_WIDTH'({$urandom, $urandom});
            if ($urandom_range(3, 0) != 0) ptw_walk_req_addr_i[2:0] = 3'b000;
            ptw_walk_resp_rdy_i = ($urandom_range(3, 0) != 0);
            mem_req_rdy_i       = ($urandom_range(3, 0) != 0);
            tick();
        end
        ptw_walk_req_vld_i  = 1'b0;
        ptw_walk_resp_rdy_i = 1'b1;
        mem_req_rdy_i       = 1'b1;
        n = 0;
        while ((exp_q.size() > 0 || ptw_walk_resp_vld_o) && n < 200) begin
            tick();
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
        chk("drain_resp_vld", ptw_walk_resp_vld_o, 0);
        chk("drain_mreq_vld", mem_req_vld_o, 0);
        chk("drain_perr", protocol_err_o, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
